// File: rtl/io_port_bank_if.sv
// CPU port bus plus board-side pins of io_port_bank, grouped for one connection.
// master = CPU/board side, slave = the bridge.
interface io_port_bank_if #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 8
);
    logic [CHANNELS-1:0]       io_wr;
    logic [CHANNELS-1:0]       io_rd;
    logic [CHANNELS*WIDTH-1:0] io_wdata;
    logic [CHANNELS*WIDTH-1:0] io_rdata;
    logic [CHANNELS*WIDTH-1:0] dev_in;
    logic [CHANNELS*WIDTH-1:0] dev_out;
    logic [CHANNELS-1:0]       out_upd;
    logic [CHANNELS-1:0]       evt;
    logic                      irq;

    modport master (
        output io_wr, io_rd, io_wdata, dev_in,
        input  io_rdata, dev_out, out_upd, evt, irq
    );

    modport slave (
        input  io_wr, io_rd, io_wdata, dev_in,
        output io_rdata, dev_out, out_upd, evt, irq
    );
endinterface

// File: rtl/io_port_bank.sv
// CPU-to-board I/O bridge: per-channel output latches or synchronised inputs with change events.
// Optional input debounce is enabled by defining IO_DEBOUNCE_EN.
module io_port_lane #(
    parameter int         WIDTH   = 8,
    parameter bit         IS_OUT  = 1'b0,
    parameter logic [7:0] DB_LAST = 8'd3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic             rd_i,
    input  logic             primed_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [WIDTH-1:0] dout_o,
    output logic             upd_o,
    output logic             evt_o
);
    if (IS_OUT) begin : g_out
        logic [WIDTH-1:0] out_q;
        logic             upd_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                out_q <= '0;
                upd_q <= 1'b0;
            end else begin
                if (wr_i) out_q <= wdata_i;
                upd_q <= wr_i;
            end
        end

        assign rdata_o = out_q;
        assign dout_o  = out_q;
        assign upd_o   = upd_q;
        assign evt_o   = 1'b0;

        logic lane_unused;
        assign lane_unused = ^{rd_i, primed_i, din_i, DB_LAST};
    end else begin : g_in
        logic [WIDTH-1:0] sync1_q, sync2_q, prev_q, acc;
        logic             evt_q, evt_d;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                sync1_q <= '0;
                sync2_q <= '0;
                prev_q  <= '0;
                evt_q   <= 1'b0;
            end else begin
                sync1_q <= din_i;
                sync2_q <= sync1_q;
                prev_q  <= acc;
                evt_q   <= evt_d;
            end
        end

        // A fresh change beats a same-cycle read so it is never lost.
        assign evt_d = (primed_i && (acc != prev_q)) || (evt_q && !rd_i);

`ifdef IO_DEBOUNCE_EN
        logic [WIDTH-1:0] acc_q;
        logic [7:0]       cnt_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (sync2_q != acc_q) begin
                if (cnt_q == DB_LAST) begin
                    acc_q <= sync2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end else begin
                cnt_q <= '0;
            end
        end

        assign acc = acc_q;

        logic lane_unused;
        assign lane_unused = ^{wr_i, wdata_i};
`else
        assign acc = sync2_q;

        logic lane_unused;
        assign lane_unused = ^{wr_i, wdata_i, DB_LAST};
`endif

        assign rdata_o = acc;
        assign dout_o  = '0;
        assign upd_o   = 1'b0;
        assign evt_o   = evt_q;
    end
endmodule

module io_port_bank #(
    parameter int                  CHANNELS        = 8,
    parameter int                  WIDTH           = 8,
    parameter logic [CHANNELS-1:0] DIR_MASK        = CHANNELS'(8'b1000_0011),
    parameter int                  DEBOUNCE_CYCLES = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    io_port_bank_if.slave bus
);
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0][WIDTH-1:0] rdata, dout;
    logic [CHANNELS-1:0]            upd, evt;
    logic [1:0]                     prime_q;
    logic                           primed;

    // Holds off events until the synchronisers have flushed post-reset levels.
    always_ff @(posedge clk_i) begin
        if (rst_i)                prime_q <= 2'd0;
        else if (prime_q != 2'd3) prime_q <= prime_q + 2'd1;
    end
    assign primed = (prime_q == 2'd3);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        io_port_lane #(
            .WIDTH   (WIDTH),
            .IS_OUT  (DIR_MASK[g]),
            .DB_LAST (DB_LAST)
        ) u_lane (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .wr_i     (bus.io_wr[g]),
            .rd_i     (bus.io_rd[g]),
            .primed_i (primed),
            .wdata_i  (bus.io_wdata[g*WIDTH +: WIDTH]),
            .din_i    (bus.dev_in[g*WIDTH +: WIDTH]),
            .rdata_o  (rdata[g]),
            .dout_o   (dout[g]),
            .upd_o    (upd[g]),
            .evt_o    (evt[g])
        );
    end

    assign bus.io_rdata = rdata;
    assign bus.dev_out  = dout;
    assign bus.out_upd  = upd;
    assign bus.evt      = evt;
    assign bus.irq      = |evt;
endmodule
